// File: rtl/booth2_wallace_mult_pipe_if.sv
// ============================================================================
// booth2_wallace_mult_pipe_if : operand/product stream bundle for the multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

interface booth2_wallace_mult_pipe_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

`default_nettype wire

// File: rtl/booth2_wallace_mult_pipe.sv
// ============================================================================
// booth2_wallace_mult_pipe : 3-stage radix-4 Booth / 4:2 Wallace multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module booth2_wallace_mult_pipe #(
  parameter int WIDTH    = 16,
  parameter bit SIGN_EXT = 1'b1
) (
  input  wire logic                 sys_clk,
  input  wire logic                 sys_rst_n,
  booth2_wallace_mult_pipe_if.slave bus
);

  localparam int PW = 2 * WIDTH;      // product width
  localparam int NR = WIDTH / 2 + 1;  // Booth rows
  localparam int RW = WIDTH + 3;      // row width incl. sign bit
  localparam int M  = WIDTH + 2;      // sign-bit position inside a row

  function automatic int next_cnt(input int c);
    if (c <= 2) return c;
    return 2 * (c / 4) + ((c % 4 == 3) ? 2 : (c % 4));
  endfunction

  function automatic int num_lvl();
    int c;
    int n;
    c = NR;
    n = 0;
    while (c > 2) begin
      c = next_cnt(c);
      n++;
    end
    return n;
  endfunction

  function automatic int lvl_cnt(input int l);
    int c;
    c = NR;
    for (int i = 0; i < l; i++) c = next_cnt(c);
    return c;
  endfunction

  function automatic int lvl_off(input int l);
    int o;
    o = 0;
    for (int i = 0; i < l; i++) o += lvl_cnt(i);
    return o;
  endfunction

  function automatic logic [PW-1:0] maj3(input logic [PW-1:0] x, y, z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  localparam int NLVL  = num_lvl();
  localparam int OFF_F = lvl_off(NLVL);
  localparam int NT    = OFF_F + 2;

  logic                   advance;
  logic                   v1_q, v2_q, v3_q;
  logic [NR-1:0][PW-1:0]  pp_d, pp_q;
  logic [PW-1:0]          sum_d, sum_q, carry_d, carry_q;
  logic [PW-1:0]          p_d, p_q;
  logic [PW-1:0]          t [NT];

  // Whole pipeline moves in lock-step; bubbles are not squeezed out.
  assign advance       = ~v3_q | bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v3_q;
  assign bus.out_p     = p_q;

  always_comb begin
    logic [WIDTH+1:0] ax;
    logic [WIDTH+2:0] bxe;
    logic [2:0]       trip;
    logic             one, two, neg, neg_prev, s;
    logic [RW-1:0]    mag, r;
    logic [M+2:0]     code;
    logic [PW-1:0]    row;
    pp_d     = '0;
    ax       = {{2{bus.in_signed & bus.in_a[WIDTH-1]}}, bus.in_a};
    bxe      = {{2{bus.in_signed & bus.in_b[WIDTH-1]}}, bus.in_b, 1'b0};
    neg_prev = 1'b0;
    for (int k = 0; k < NR; k++) begin
      trip = bxe[2*k +: 3];
      one  = trip[1] ^ trip[0];
      two  = (trip == 3'b011) || (trip == 3'b100);
      neg  = trip[2] & ~(trip[1] & trip[0]);
      mag  = one ? {ax[WIDTH+1], ax} : (two ? {ax, 1'b0} : '0);
      r    = neg ? ~mag : mag;
      s    = r[RW-1];
      code = '0;
      if (SIGN_EXT) begin
        // Sign-coded prefixes; their constant offsets sum to 2^(2*WIDTH+4) == 0 mod 2^PW.
        code = (k == 0) ? {~s, s, s, r[M-1:0]} : {1'b0, 1'b1, ~s, r[M-1:0]};
        row  = PW'(code);
      end else begin
        row = {{(PW-RW){s}}, r};
      end
      row = row << (2 * k);
      // Previous row's negation +1 sits in this row's empty low gap.
      if (k > 0) row = row | (PW'(neg_prev) << (2 * k - 2));
      pp_d[k]  = row;
      neg_prev = neg;
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_l0
    assign t[r] = pp_q[r];
  end

  for (genvar L = 0; L < NLVL; L++) begin : g_lvl
    localparam int CI = lvl_cnt(L);
    localparam int OI = lvl_off(L);
    localparam int OO = lvl_off(L + 1);
    localparam int NG = CI / 4;
    for (genvar g = 0; g < NG; g++) begin : g_c42
      logic [PW-1:0] s1, c1;
      assign s1          = t[OI+4*g] ^ t[OI+4*g+1] ^ t[OI+4*g+2];
      assign c1          = maj3(t[OI+4*g], t[OI+4*g+1], t[OI+4*g+2]) << 1;
      assign t[OO+2*g]   = s1 ^ c1 ^ t[OI+4*g+3];
      assign t[OO+2*g+1] = maj3(s1, c1, t[OI+4*g+3]) << 1;
    end
    if (CI % 4 == 3) begin : g_c32
      assign t[OO+2*NG]   = t[OI+4*NG] ^ t[OI+4*NG+1] ^ t[OI+4*NG+2];
      assign t[OO+2*NG+1] = maj3(t[OI+4*NG], t[OI+4*NG+1], t[OI+4*NG+2]) << 1;
    end else if (CI % 4 != 0) begin : g_pass
      for (genvar r = 0; r < CI % 4; r++) begin : g_wire
        assign t[OO+2*NG+r] = t[OI+4*NG+r];
      end
    end
  end

  assign sum_d   = t[OFF_F];
  assign carry_d = t[OFF_F+1];
  assign p_d     = sum_q + carry_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      pp_q    <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      p_q     <= '0;
    end else if (advance) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (bus.in_valid) pp_q <= pp_d;
      if (v1_q) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
      if (v2_q) p_q <= p_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth2_wallace_mult_pipe.sv
`default_nettype none

module tb_booth2_wallace_mult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth2_wallace_mult_pipe_if #(.WIDTH(8))  b8 ();
  booth2_wallace_mult_pipe_if #(.WIDTH(16)) b16 ();

  booth2_wallace_mult_pipe #(.WIDTH(8), .SIGN_EXT(1'b1)) u8 (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(b8));
  booth2_wallace_mult_pipe #(.WIDTH(16), .SIGN_EXT(1'b1)) u16 (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(b16));

  int tests = 0;
  int fails = 0;
  int rmode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
  logic [15:0] q8 [$];
  logic [31:0] q16 [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic sg, input logic [7:0] a, input logic [7:0] b);
    longint x, y;
    x = sg ? longint'($signed(a)) : longint'(a);
    y = sg ? longint'($signed(b)) : longint'(b);
    return 16'(x * y);
  endfunction

  function automatic logic [31:0] model16(input logic sg, input logic [15:0] a, input logic [15:0] b);
    longint x, y;
    x = sg ? longint'($signed(a)) : longint'(a);
    y = sg ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  // Consumer-side ready, changed just after each rising edge
  initial begin
    b8.out_ready  = 1'b1;
    b16.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      b8.out_ready  = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      b16.out_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitors: pop expected on each output handshake, check stability under stall
  initial begin
    logic hold = 1'b0;
    logic [15:0] held_p = '0;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold) begin
          chk("hold8_valid", 64'(b8.out_valid), 64'd1);
          chk("hold8_p", 64'(b8.out_p), 64'(held_p));
        end
        if (b8.out_valid && b8.out_ready) begin
          if (q8.size() == 0) begin
            tests++; fails++;
            $display("FAIL stray8: got %0h expected no output", b8.out_p);
          end else begin
            e = q8.pop_front();
            chk("p8", 64'(b8.out_p), 64'(e));
          end
        end
        hold   = b8.out_valid && !b8.out_ready;
        held_p = b8.out_p;
      end
    end
  end

  initial begin
    logic hold = 1'b0;
    logic [31:0] held_p = '0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold) begin
          chk("hold16_valid", 64'(b16.out_valid), 64'd1);
          chk("hold16_p", 64'(b16.out_p), 64'(held_p));
        end
        if (b16.out_valid && b16.out_ready) begin
          if (q16.size() == 0) begin
            tests++; fails++;
            $display("FAIL stray16: got %0h expected no output", b16.out_p);
          end else begin
            e = q16.pop_front();
            chk("p16", 64'(b16.out_p), 64'(e));
          end
        end
        hold   = b16.out_valid && !b16.out_ready;
        held_p = b16.out_p;
      end
    end
  end

  task automatic send8(input logic sg, input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    int n = 0;
    @(negedge clk);
    b8.in_valid = 1'b1; b8.in_signed = sg; b8.in_a = a; b8.in_b = b;
    while (!b8.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b8.in_ready) begin
      tests++; fails++;
      $display("FAIL send8_timeout: got in_ready 0 expected 1");
    end else q8.push_back(e);
  endtask

  task automatic send16(input logic sg, input logic [15:0] a, input logic [15:0] b, input logic [31:0] e);
    int n = 0;
    @(negedge clk);
    b16.in_valid = 1'b1; b16.in_signed = sg; b16.in_a = a; b16.in_b = b;
    while (!b16.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b16.in_ready) begin
      tests++; fails++;
      $display("FAIL send16_timeout: got in_ready 0 expected 1");
    end else q16.push_back(e);
  endtask

  task automatic idle8();
    @(negedge clk);
    b8.in_valid = 1'b0; b8.in_signed = 1'($urandom);
    b8.in_a = 8'($urandom); b8.in_b = 8'($urandom);
  endtask

  task automatic idle16();
    @(negedge clk);
    b16.in_valid = 1'b0; b16.in_signed = 1'($urandom);
    b16.in_a = 16'($urandom); b16.in_b = 16'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        sgv [5];
    logic [7:0]  av  [5];
    logic [7:0]  bv  [5];
    logic [15:0] ev  [5];
    int idx, lat, seen;
    logic sg;
    logic [7:0]  a8, bb8;
    logic [15:0] a16, bb16;

    sgv[0] = 0; av[0] = 8'h12; bv[0] = 8'h34; ev[0] = 16'h03A8;
    sgv[1] = 1; av[1] = 8'h85; bv[1] = 8'h03; ev[1] = 16'hFE8F;
    sgv[2] = 0; av[2] = 8'h85; bv[2] = 8'h03; ev[2] = 16'h018F;
    sgv[3] = 1; av[3] = 8'hFF; bv[3] = 8'h7F; ev[3] = 16'hFF81;
    sgv[4] = 0; av[4] = 8'hAA; bv[4] = 8'h55; ev[4] = 16'h3872;

    b8.in_valid = 0;  b8.in_signed = 0;  b8.in_a = 0;  b8.in_b = 0;
    b16.in_valid = 0; b16.in_signed = 0; b16.in_a = 0; b16.in_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid8", 64'(b8.out_valid), 64'd0);
    chk("rst_p8", 64'(b8.out_p), 64'd0);
    chk("rst_ready8", 64'(b8.in_ready), 64'd1);
    chk("rst_valid16", 64'(b16.out_valid), 64'd0);
    chk("rst_p16", 64'(b16.out_p), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: first out_valid seen after the third rising edge counting the accept edge
    send8(1, 8'h80, 8'h80, 16'h4000);
    idle8();
    lat = 1;
    while (!b8.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency8", 64'(lat), 64'd3);
    repeat (3) @(negedge clk);

    // Back-to-back directed, mixed modes
    send8(1, 8'h7F, 8'h80, 16'hC080);
    send8(0, 8'hFF, 8'hFF, 16'hFE01);
    send8(0, 8'h00, 8'hAB, 16'h0000);
    send8(1, 8'hFF, 8'hFF, 16'h0001);
    send8(1, 8'h00, 8'hAB, 16'h0000);
    send8(1, 8'h7F, 8'h7F, 16'h3F01);
    send8(0, 8'h80, 8'h80, 16'h4000);
    idle8();
    send16(1, 16'h8000, 16'h7FFF, 32'hC0008000);
    send16(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    send16(1, 16'h8000, 16'h8000, 32'h40000000);
    send16(1, 16'h1234, 16'hFFFE, 32'hFFFFDB98);
    send16(0, 16'h1234, 16'h0010, 32'h00012340);
    idle16();
    repeat (8) @(negedge clk);

    // Back-pressure: consumer stalled for 6 cycles while 5 pairs are offered
    rmode = 2;
    repeat (2) @(negedge clk);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (idx < 5) begin
        b8.in_valid = 1'b1; b8.in_signed = sgv[idx]; b8.in_a = av[idx]; b8.in_b = bv[idx];
        if (b8.in_ready) begin
          q8.push_back(ev[idx]);
          idx++;
        end
      end
    end
    chk("bp_accepted", 64'(idx), 64'd3);
    chk("bp_in_ready", 64'(b8.in_ready), 64'd0);
    rmode = 0;
    for (int i = 3; i < 5; i++) send8(sgv[i], av[i], bv[i], ev[i]);
    idle8();
    repeat (8) @(negedge clk);

    // Reset with three products in flight
    rmode = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) send8(sgv[i], av[i], bv[i], ev[i]);
    idle8();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(b8.out_valid), 64'd0);
    chk("midrst_p", 64'(b8.out_p), 64'd0);
    q8.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    rmode = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b8.out_valid) seen++;
    end
    chk("stale_after_rst", 64'(seen), 64'd0);

    // Random operands, random gaps and random consumer stalls
    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      sg = 1'($urandom); a8 = 8'($urandom); bb8 = 8'($urandom);
      send8(sg, a8, bb8, model8(sg, a8, bb8));
      if ($urandom_range(0, 3) == 0) idle8();
    end
    idle8();
    for (int i = 0; i < 200; i++) begin
      sg = 1'($urandom); a16 = 16'($urandom); bb16 = 16'($urandom);
      send16(sg, a16, bb16, model16(sg, a16, bb16));
      if ($urandom_range(0, 3) == 0) idle16();
    end
    idle16();
    rmode = 0;
    repeat (20) @(negedge clk);
    chk("drain8", 64'(q8.size()), 64'd0);
    chk("drain16", 64'(q16.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
